// File: rtl/register_file_pkg.sv
// Shared types for the architectural register file with rename tags.
package register_file_pkg;

    // Default widths, mirroring the project-wide REG_WIDTH / ROB_WIDTH values.
    localparam int DEF_REG_WIDTH = 5;
    localparam int DEF_ROB_WIDTH = 3;

    // Where an operand lookup takes its answer from, in decreasing priority.
    typedef enum logic [2:0] {
        SRC_ZERO   = 3'd0,  // x0 hard-wired to zero
        SRC_REG    = 3'd1,  // no in-flight owner: architectural value
        SRC_BYPASS = 3'd2,  // owner is committing this very cycle
        SRC_ROB    = 3'd3,  // owner has finished, value sits in the ROB
        SRC_WAIT   = 3'd4   // owner still executing: hand out its tag
    } lookup_src_t;

endpackage

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags.
// Takes the ROB commit stream, tracks which in-flight ROB entry owns each
// register, and answers the decoder's two operand lookups combinationally
// with either a value or a dependency tag.
module register_file
    import register_file_pkg::*;
#(
    parameter int REG_WIDTH = DEF_REG_WIDTH,
    parameter int ROB_WIDTH = DEF_ROB_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush,

    // decoder operand lookup
    input  logic [REG_WIDTH-1:0] dec_rs1,
    input  logic [REG_WIDTH-1:0] dec_rs2,
    output logic [31:0]          dec_val_j,
    output logic [31:0]          dec_val_k,
    output logic                 dec_has_dep_j,
    output logic                 dec_has_dep_k,
    output logic [ROB_WIDTH-1:0] dec_dep_j,
    output logic [ROB_WIDTH-1:0] dec_dep_k,

    // decoder rename
    input  logic                 dec_rdy,
    input  logic [REG_WIDTH-1:0] dec_rd,
    input  logic [ROB_WIDTH-1:0] dec_rob_id,

    // ROB commit stream
    input  logic [REG_WIDTH-1:0] commit_reg_id,
    input  logic [31:0]          commit_data,
    input  logic [ROB_WIDTH-1:0] commit_rob_id,

    // ROB register query
    output logic [ROB_WIDTH-1:0] rob_id_j,
    output logic [ROB_WIDTH-1:0] rob_id_k,
    input  logic                 rob_ready_j,
    input  logic                 rob_ready_k,
    input  logic [31:0]          rob_data_j,
    input  logic [31:0]          rob_data_k
);

    localparam int NUM_REGS = 1 << REG_WIDTH;

    logic [31:0]          regs [NUM_REGS];
    logic [NUM_REGS-1:0]  busy;
    logic [ROB_WIDTH-1:0] tag  [NUM_REGS];

    logic        update_en;
    logic        commit_en;
    logic        rename_en;
    lookup_src_t src_j;
    lookup_src_t src_k;

    // Decide where one operand's answer comes from. Flush suppresses the
    // commit bypass because the ROB head is wrong-path during that cycle.
    function automatic lookup_src_t operand_lookup(
        input logic [REG_WIDTH-1:0] rs,
        input logic                 rs_busy,
        input logic [ROB_WIDTH-1:0] rs_tag,
        input logic                 rob_ready,
        input logic [REG_WIDTH-1:0] c_reg,
        input logic [ROB_WIDTH-1:0] c_rob,
        input logic                 c_flush
    );
        if (rs == '0)
            return SRC_ZERO;
        else if (!rs_busy)
            return SRC_REG;
        else if (!c_flush && (c_reg == rs) && (c_rob == rs_tag))
            return SRC_BYPASS;
        else if (rob_ready)
            return SRC_ROB;
        else
            return SRC_WAIT;
    endfunction

    // Operand value for a given source; waiting operands read as zero.
    function automatic logic [31:0] operand_value(
        input lookup_src_t src,
        input logic [31:0] reg_val,
        input logic [31:0] bypass_val,
        input logic [31:0] rob_val
    );
        case (src)
            SRC_REG:    return reg_val;
            SRC_BYPASS: return bypass_val;
            SRC_ROB:    return rob_val;
            default:    return 32'd0;
        endcase
    endfunction

    assign update_en = rdy_in && !flush;
    assign commit_en = update_en && (commit_reg_id != '0);
    assign rename_en = update_en && dec_rdy && (dec_rd != '0);

    // The ROB is always asked about the current owner of each source.
    assign rob_id_j = tag[dec_rs1];
    assign rob_id_k = tag[dec_rs2];

    // Lookup source selection for both operands from pre-rename state.
    always_comb begin
        src_j = operand_lookup(dec_rs1, busy[dec_rs1], tag[dec_rs1], rob_ready_j,
                               commit_reg_id, commit_rob_id, flush);
        src_k = operand_lookup(dec_rs2, busy[dec_rs2], tag[dec_rs2], rob_ready_k,
                               commit_reg_id, commit_rob_id, flush);
    end

    // Operand j answer: value or dependency tag.
    always_comb begin
        dec_val_j     = operand_value(src_j, regs[dec_rs1], commit_data, rob_data_j);
        dec_has_dep_j = (src_j == SRC_WAIT);
        dec_dep_j     = tag[dec_rs1];
    end

    // Operand k answer: value or dependency tag.
    always_comb begin
        dec_val_k     = operand_value(src_k, regs[dec_rs2], commit_data, rob_data_k);
        dec_has_dep_k = (src_k == SRC_WAIT);
        dec_dep_k     = tag[dec_rs2];
    end

    // Architectural values: written by every non-x0 commit, even when a
    // newer owner exists, so the value is correct once that owner retires.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= 32'd0;
            end
        end else if (commit_en) begin
            regs[commit_reg_id] <= commit_data;
        end
    end

    // Ownership tracking. The rename assignment follows the commit release
    // so that a same-cycle rename of the committing register keeps it busy.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                tag[r] <= '0;
            end
        end else if (rdy_in && flush) begin
            busy <= '0;
        end else begin
            if (commit_en && busy[commit_reg_id] && (tag[commit_reg_id] == commit_rob_id)) begin
                busy[commit_reg_id] <= 1'b0;
            end
            if (rename_en) begin
                busy[dec_rd] <= 1'b1;
                tag[dec_rd]  <= dec_rob_id;
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: expected lookup answers are queued
// as each stimulus cycle is driven and compared once the outputs settle.
module tb_register_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [31:0] dec_val_j;
    logic [31:0] dec_val_k;
    logic        dec_has_dep_j;
    logic        dec_has_dep_k;
    logic [2:0]  dec_dep_j;
    logic [2:0]  dec_dep_k;
    logic        dec_rdy;
    logic [4:0]  dec_rd;
    logic [2:0]  dec_rob_id;
    logic [4:0]  commit_reg_id;
    logic [31:0] commit_data;
    logic [2:0]  commit_rob_id;
    logic [2:0]  rob_id_j;
    logic [2:0]  rob_id_k;
    logic        rob_ready_j;
    logic        rob_ready_k;
    logic [31:0] rob_data_j;
    logic [31:0] rob_data_k;

    typedef struct packed {
        logic [2:0]  rj;
        logic [31:0] vj;
        logic        hj;
        logic [2:0]  dj;
        logic [2:0]  rk;
        logic [31:0] vk;
        logic        hk;
        logic [2:0]  dk;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    register_file dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush         (flush),
        .dec_rs1       (dec_rs1),
        .dec_rs2       (dec_rs2),
        .dec_val_j     (dec_val_j),
        .dec_val_k     (dec_val_k),
        .dec_has_dep_j (dec_has_dep_j),
        .dec_has_dep_k (dec_has_dep_k),
        .dec_dep_j     (dec_dep_j),
        .dec_dep_k     (dec_dep_k),
        .dec_rdy       (dec_rdy),
        .dec_rd        (dec_rd),
        .dec_rob_id    (dec_rob_id),
        .commit_reg_id (commit_reg_id),
        .commit_data   (commit_data),
        .commit_rob_id (commit_rob_id),
        .rob_id_j      (rob_id_j),
        .rob_id_k      (rob_id_k),
        .rob_ready_j   (rob_ready_j),
        .rob_ready_k   (rob_ready_k),
        .rob_data_j    (rob_data_j),
        .rob_data_k    (rob_data_k)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_lk(input string name,
                             input logic [2:0] rj, input logic [31:0] vj,
                             input logic hj, input logic [2:0] dj,
                             input logic [2:0] rk, input logic [31:0] vk,
                             input logic hk, input logic [2:0] dk);
        exp_t e;
        e = '{rj: rj, vj: vj, hj: hj, dj: dj, rk: rk, vk: vk, hk: hk, dk: dk};
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // Let the combinational outputs settle, then drain the scoreboard.
    task automatic compare_out();
        exp_t  e;
        string n;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check_val({n, ".rob_id_j"},  {29'd0, rob_id_j},      {29'd0, e.rj});
            check_val({n, ".val_j"},     dec_val_j,              e.vj);
            check_val({n, ".has_dep_j"}, {31'd0, dec_has_dep_j}, {31'd0, e.hj});
            if (e.hj) check_val({n, ".dep_j"}, {29'd0, dec_dep_j}, {29'd0, e.dj});
            check_val({n, ".rob_id_k"},  {29'd0, rob_id_k},      {29'd0, e.rk});
            check_val({n, ".val_k"},     dec_val_k,              e.vk);
            check_val({n, ".has_dep_k"}, {31'd0, dec_has_dep_k}, {31'd0, e.hk});
            if (e.hk) check_val({n, ".dep_k"}, {29'd0, dec_dep_k}, {29'd0, e.dk});
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic clear_inputs();
        rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0;
        dec_rs1 = 5'd0; dec_rs2 = 5'd0;
        dec_rdy = 1'b0; dec_rd = 5'd0; dec_rob_id = 3'd0;
        commit_reg_id = 5'd0; commit_data = 32'd0; commit_rob_id = 3'd0;
        rob_ready_j = 1'b0; rob_ready_k = 1'b0;
        rob_data_j = 32'd0; rob_data_k = 32'd0;
    endtask

    task automatic commit(input logic [4:0] r, input logic [31:0] d, input logic [2:0] id);
        commit_reg_id = r; commit_data = d; commit_rob_id = id;
    endtask

    task automatic rename(input logic [4:0] r, input logic [2:0] id);
        dec_rdy = 1'b1; dec_rd = r; dec_rob_id = id;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        rst_in = 1'b1;
        repeat (2) tick();
        clear_inputs();

        // Reset state
        dec_rs1 = 5'd5; dec_rs2 = 5'd0;
        expect_lk("reset", 3'd0, 32'd0, 1'b0, 3'd0, 3'd0, 32'd0, 1'b0, 3'd0);
        compare_out();

        // Rename x3 -> tag 2; same-cycle lookup still sees the old state
        rename(5'd3, 3'd2); dec_rs1 = 5'd3;
        expect_lk("pre_rename", 3'd0, 32'd0, 1'b0, 3'd0, 3'd0, 32'd0, 1'b0, 3'd0);
        compare_out();
        tick();
        clear_inputs(); dec_rs1 = 5'd3; dec_rs2 = 5'd3;
        expect_lk("dep", 3'd2, 32'd0, 1'b1, 3'd2, 3'd2, 32'd0, 1'b1, 3'd2);
        compare_out();
        rob_ready_j = 1'b1; rob_data_j = 32'h1234;
        rob_ready_k = 1'b1; rob_data_k = 32'h5678;
        expect_lk("rob_fwd", 3'd2, 32'h1234, 1'b0, 3'd0, 3'd2, 32'h5678, 1'b0, 3'd0);
        compare_out();
        tick();

        // Commit bypass, then value from regs
        clear_inputs(); dec_rs1 = 5'd3; dec_rs2 = 5'd3;
        commit(5'd3, 32'hAA, 3'd2);
        expect_lk("bypass", 3'd2, 32'hAA, 1'b0, 3'd0, 3'd2, 32'hAA, 1'b0, 3'd0);
        compare_out();
        tick();
        clear_inputs(); dec_rs1 = 5'd3;
        expect_lk("after_commit", 3'd2, 32'hAA, 1'b0, 3'd0, 3'd0, 32'd0, 1'b0, 3'd0);
        compare_out();

        // Stale commit against a newer owner
        rename(5'd4, 3'd1); tick();
        rename(5'd4, 3'd5); tick();
        clear_inputs(); dec_rs1 = 5'd4;
        commit(5'd4, 32'd7, 3'd1);
        expect_lk("stale_commit", 3'd5, 32'd0, 1'b1, 3'd5, 3'd0, 32'd0, 1'b0, 3'd0);
        compare_out();
        tick();
        clear_inputs(); dec_rs1 = 5'd4;
        expect_lk("still_dep", 3'd5, 32'd0, 1'b1, 3'd5, 3'd0, 32'd0, 1'b0, 3'd0);
        compare_out();
        commit(5'd4, 32'h55, 3'd5); rename(5'd4, 3'd6);
        expect_lk("bypass_rename", 3'd5, 32'h55, 1'b0, 3'd0, 3'd0, 32'd0, 1'b0, 3'd0);
        compare_out();
        tick();
        clear_inputs(); dec_rs1 = 5'd4;
        expect_lk("rename_wins", 3'd6, 32'd0, 1'b1, 3'd6, 3'd0, 32'd0, 1'b0, 3'd0);
        compare_out();
        flush = 1'b1;
        tick();
        clear_inputs(); dec_rs1 = 5'd4;
        expect_lk("flush_clears", 3'd6, 32'h55, 1'b0, 3'd0, 3'd0, 32'd0, 1'b0, 3'd0);
        compare_out();

        // Flush ignores commit and rename
        commit(5'd7, 32'h77, 3'd0); tick();
        commit(5'd8, 32'h88, 3'd0); tick();
        clear_inputs(); rename(5'd7, 3'd3); tick();
        clear_inputs(); flush = 1'b1;
        commit(5'd7, 32'h99, 3'd3); rename(5'd8, 3'd1);
        dec_rs1 = 5'd7; dec_rs2 = 5'd8;
        expect_lk("flush_no_bypass", 3'd3, 32'd0, 1'b1, 3'd3, 3'd0, 32'h88, 1'b0, 3'd0);
        compare_out();
        tick();
        clear_inputs(); dec_rs1 = 5'd7; dec_rs2 = 5'd8;
        expect_lk("after_flush", 3'd3, 32'h77, 1'b0, 3'd0, 3'd0, 32'h88, 1'b0, 3'd0);
        compare_out();

        // x0 is never written or renamed
        rename(5'd0, 3'd4); commit(5'd0, 32'hFFFF, 3'd4);
        dec_rs1 = 5'd0; dec_rs2 = 5'd0;
        tick();
        clear_inputs();
        expect_lk("x0", 3'd0, 32'd0, 1'b0, 3'd0, 3'd0, 32'd0, 1'b0, 3'd0);
        compare_out();

        // rdy_in low holds state
        rdy_in = 1'b0; commit(5'd3, 32'hBEEF, 3'd0); rename(5'd9, 3'd2);
        tick();
        clear_inputs(); dec_rs1 = 5'd3; dec_rs2 = 5'd9;
        expect_lk("hold", 3'd2, 32'hAA, 1'b0, 3'd0, 3'd0, 32'd0, 1'b0, 3'd0);
        compare_out();

        // Reset beats flush and clears everything
        rename(5'd4, 3'd7); tick();
        clear_inputs(); rst_in = 1'b1; flush = 1'b1; commit(5'd5, 32'h1, 3'd0);
        tick();
        clear_inputs(); dec_rs1 = 5'd4; dec_rs2 = 5'd3;
        expect_lk("reset_again", 3'd0, 32'd0, 1'b0, 3'd0, 3'd0, 32'd0, 1'b0, 3'd0);
        compare_out();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file with rename tags.
- Consumes the ROB commit stream (register id, data, ROB id) and answers the decoder's operand lookups.
- Tracks, per register, whether a newer in-flight instruction owns it and which ROB entry that is.
- For owned registers it queries the ROB (rob_id_j/k out, ready/data back) and returns either a value or a dependency tag. It is the receiving end of the ROB's commit and register-query interfaces.

Parameters:
- REG_WIDTH, 5 (params.v `REG_WIDTH): register index width; 2^REG_WIDTH registers.
- ROB_WIDTH, 3 (params.v `ROB_WIDTH): ROB entry id width.

Ports:
- clk_in  in  1  clock; all state updates on rising edge
- rst_in  in  1  synchronous, active-high reset
- rdy_in  in  1  global enable; low = hold all state
- flush  in  1  misprediction flush (valid only with rdy_in)
- dec_rs1  in  REG_WIDTH  source register j
- dec_rs2  in  REG_WIDTH  source register k
- dec_val_j  out  32  operand j value (valid when !dec_has_dep_j)
- dec_val_k  out  32  operand k value
- dec_has_dep_j  out  1  operand j waits on ROB entry
- dec_has_dep_k  out  1  operand k waits on ROB entry
- dec_dep_j  out  ROB_WIDTH  ROB id producing j
- dec_dep_k  out  ROB_WIDTH  ROB id producing k
- dec_rdy  in  1  decoder issuing an instruction this cycle
- dec_rd  in  REG_WIDTH  destination register of issued instruction
- dec_rob_id  in  ROB_WIDTH  ROB entry assigned to issued instruction
- commit_reg_id  in  REG_WIDTH  committing destination; 0 = no write
- commit_data  in  32  committed value
- commit_rob_id  in  ROB_WIDTH  ROB id being committed
- rob_id_j  out  ROB_WIDTH  tag queried in ROB for j
- rob_id_k  out  ROB_WIDTH  tag queried in ROB for k
- rob_ready_j  in  1  ROB entry j has its result
- rob_ready_k  in  1  ROB entry k has its result
- rob_data_j  in  32  ROB result for j
- rob_data_k  in  32  ROB result for k

Behaviour:
- State: regs[r] (32 bit), busy[r], tag[r] (ROB_WIDTH) for all registers.
- Reset (rst_in=1 at edge): all regs = 0, busy = 0, tag = 0. Outputs are combinational; with reset state, every lookup returns value 0 with no dependency.
- Register 0: reads always return value 0, has_dep=0. It is never written and never marked busy.
- Lookup, purely combinational from current state. The j path, in priority order (k is identical):
  1. rs==0 -> val 0, no dep.
  2. !busy[rs] -> val regs[rs], no dep.
  3. commit_reg_id==rs and commit_rob_id==tag[rs], with no flush this cycle -> val commit_data, no dep (same-cycle commit bypass).
  4. rob_ready_j -> val rob_data_j, no dep.
  5. Otherwise -> has_dep=1, dep=tag[rs], val=0.
- rob_id_j = tag[dec_rs1] and rob_id_k = tag[dec_rs2], always driven.
- Lookup sees pre-rename state. An instruction reading its own rd (x1 = x1 + 1) gets the older producer, never itself.
- Update rules, at the edge when rdy_in=1 and flush=0:
  - Commit (commit_reg_id!=0): regs[commit_reg_id] <= commit_data. If busy and tag==commit_rob_id, then busy <= 0. A tag mismatch leaves busy/tag untouched (a newer owner exists).
  - Rename (dec_rdy and dec_rd!=0): busy[dec_rd] <= 1, tag[dec_rd] <= dec_rob_id.
  - Rename and commit to the same register in one cycle: the value is written, and rename wins for busy/tag (busy=1, tag=dec_rob_id).
- Flush (flush=1, rdy_in=1): every busy <= 0. Commit and rename inputs are ignored that cycle (the ROB is resetting and its head is wrong-path); regs are unchanged.
- rdy_in=0: no state change; combinational outputs still follow inputs.
- Reset has priority over flush and over any update.
- Tag ids wrap modulo 2^ROB_WIDTH; only equality compares are used, with no ordering.

Decomposition:
- REG_WIDTH and ROB_WIDTH come from params.v; add no new shared constants.
- There is no sub-module. The two lookup paths are a repeated generate/function block (operand_lookup) inside this module, not a separate file.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> val_j=0, val_k=0, both has_dep=0.
- Issue rd=3 with rob_id 2 (rob_ready_j=0), next cycle read rs1=3 -> has_dep_j=1, dep_j=2, rob_id_j=2. Drive rob_ready_j=1, rob_data_j=0x1234 -> val_j=0x1234, has_dep_j=0.
- With x3 busy on tag 2, commit reg 3 data 0xAA rob 2 while reading rs1=3 that cycle -> val_j=0xAA, no dep. Next cycle busy clear, val_j=0xAA from regs.
- Rename x4 to tag 1, then to tag 5. Commit reg 4 rob 1 data 7 -> regs[4]=7 but read still shows dep=5. Same-cycle commit (4, rob 5) plus rename (4, rob 6) -> busy with tag 6, regs[4] updated.
- Rename x7 to tag 3, assert flush with commit reg 7 data 0x99 rob 3 and dec_rdy rd=8 -> x7 and x8 not busy; regs[7] keeps its old value; read rs1=8 gives the old regs value.
- dec_rdy rd=0 rob 4, and commit reg 0 data 0xFFFF -> read rs1=0 gives 0 and no dep. Holding rdy_in=0 during a commit -> no register changes.
